// File: rtl/bpred_pkg.sv
// Shared types for the 2-bit saturating branch predictor controller.
// Counter encoding, saturating update and controller state.
package bpred_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'd0,
      WEAK_NT   = 2'd1,
      WEAK_T    = 2'd2,
      STRONG_T  = 2'd3
   } ctr_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ctrl_state_t;

   localparam ctr_t CTR_INIT = WEAK_NT;

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      unique case (c)
         STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
         STRONG_T:  n = taken ? STRONG_T : WEAK_T;
         default:   n = c;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bpred_inflight_fifo.sv
// In-order queue of outstanding predictions ({idx, pred}).
// Synchronous reset and clear; no pass-through when full.
module bpred_inflight_fifo #(
   parameter int IDX_W = 6,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [IDX_W-1:0] push_idx_i,
   input  logic             push_pred_i,
   input  logic             pop_i,
   output logic [IDX_W-1:0] head_idx_o,
   output logic             head_pred_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDX_W-1:0] idx_q  [DEPTH];
   logic             pred_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW:0]      cnt_q, cnt_d;

   always_comb begin
      wr_d  = push_i ? wr_q + 1'b1 : wr_q;
      rd_d  = pop_i  ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q;
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         idx_q[wr_q]  <= push_idx_i;
         pred_q[wr_q] <= push_pred_i;
      end
   end

   assign head_idx_o  = idx_q[rd_q];
   assign head_pred_o = pred_q[rd_q];
   assign full_o      = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/bpred_table_ctrl.sv
// Branch predictor table controller: init sweep, lookup, in-order resolve.
// Define BPRED_GSHARE_EN to XOR a global history register into the index.
module bpred_table_ctrl
   import bpred_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int PC_W    = 32,
   parameter int DEPTH   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            lookup_valid,
   input  logic [PC_W-1:0] lookup_pc,
   output logic            lookup_ready,
   output logic            pred_taken,
   input  logic            resolve_valid,
   input  logic            resolve_taken,
   input  logic            flush,
   output logic            mispredict,
   output logic            init_busy
);

   localparam int IDX_W = $clog2(ENTRIES);

   ctrl_state_t      state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             mispredict_q, mispredict_d;
   ctr_t             tbl_q [ENTRIES];

   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] head_idx;
   logic             head_pred;
   logic             q_full, q_empty;
   logic             run, push, pop;

   logic unused_pc;
   assign unused_pc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

`ifdef BPRED_GSHARE_EN
   logic [IDX_W-1:0] ghr_q;

   always_ff @(posedge clk) begin
      if (reset)
         ghr_q <= '0;
      else if (pop)
         ghr_q <= {ghr_q[IDX_W-2:0], resolve_taken};
   end

   assign lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr_q;
`else
   assign lookup_idx = lookup_pc[IDX_W+1:2];
`endif

   assign run          = (state_q == RUN);
   assign init_busy    = ~run;
   assign lookup_ready = run & ~q_full;
   assign pred_taken   = tbl_q[lookup_idx][1];
   assign push         = lookup_valid & lookup_ready & ~flush;
   assign pop          = run & resolve_valid & ~q_empty & ~flush;
   assign mispredict   = mispredict_q;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      mispredict_d = pop & (head_pred ^ resolve_taken);
      if (!run) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == IDX_W'(ENTRIES - 1))
            state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= INIT;
         ptr_q        <= '0;
         mispredict_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         mispredict_q <= mispredict_d;
      end
   end

   // Counters are cleared by the sweep rather than by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (!run)
            tbl_q[ptr_q] <= CTR_INIT;
         else if (pop)
            tbl_q[head_idx] <= ctr_next(tbl_q[head_idx], resolve_taken);
      end
   end

   bpred_inflight_fifo #(
      .IDX_W (IDX_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (flush),
      .push_i      (push),
      .push_idx_i  (lookup_idx),
      .push_pred_i (pred_taken),
      .pop_i       (pop),
      .head_idx_o  (head_idx),
      .head_pred_o (head_pred),
      .full_o      (q_full),
      .empty_o     (q_empty)
   );

endmodule
